// File: rtl/debug_mem_dump_if.sv
// Handshake bundle between debug_mem_dump, the data-memory debug read port and the UART transmitter.
// The master modport is the dump engine; the slave modport is its environment (memory + TX + command decoder).
interface debug_mem_dump_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
);
  logic               i_start;
  logic               o_debug;
  logic [NB_DATA-1:0] o_debug_mem_addr;
  logic [NB_DATA-1:0] i_debug_mem_r_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               i_tx_done;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_debug_mem_r_data, i_tx_done,
    output o_debug, o_debug_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_debug_mem_r_data, i_tx_done,
    input  o_debug, o_debug_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/debug_mem_dump.sv
// Walks the whole data memory through the debug read port and streams each word MSB-byte first to a UART TX.
// Optional: define DUMP_CHECKSUM_EN to append one XOR checksum byte after the last data byte.
module debug_mem_dump #(
  parameter int NB_DATA               = 32,
  parameter int NB_BYTE               = 8,
  parameter int N_DATA_MEM_ADDR_BYTES = 128,
  parameter int N_DATA_MEM_ADDR_WORDS = N_DATA_MEM_ADDR_BYTES / 4,
  parameter int NB_ADDR_MEM_WORDS     = $clog2(N_DATA_MEM_ADDR_WORDS)
) (
  input logic              i_clk,
  input logic              i_reset,
  debug_mem_dump_if.master bus
);

  localparam logic [NB_ADDR_MEM_WORDS-1:0] LAST_WORD =
    NB_ADDR_MEM_WORDS'(N_DATA_MEM_ADDR_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM_SEND,
    ST_CSUM_WAIT,
`endif
    ST_FIN
  } state_t;

  state_t                       state_q, state_d;
  logic [NB_ADDR_MEM_WORDS-1:0] word_q, word_d;
  logic [1:0]                   byte_q, byte_d;
  logic [NB_DATA-1:0]           shift_q, shift_d;
  logic [NB_BYTE-1:0]           tx_data_q, tx_data_d;
  logic                         tx_start_q, tx_start_d;
  logic                         done_q, done_d;
  logic [NB_DATA-1:0]           shifted;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]           csum_q, csum_d;
`endif

  assign shifted = shift_q << NB_BYTE;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Registered pulses are decided on the transition into SEND/FIN so they line up with those states.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          word_d  = '0;
          state_d = ST_REQ;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_REQ: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d    = bus.i_debug_mem_r_data;
        byte_d     = '0;
        tx_data_d  = bus.i_debug_mem_r_data[NB_DATA-1 -: NB_BYTE];
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q ^ tx_data_q;
`endif
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) begin
          shift_d = shifted;
          if (byte_q != 2'd3) begin
            byte_d     = byte_q + 2'd1;
            tx_data_d  = shifted[NB_DATA-1 -: NB_BYTE];
            tx_start_d = 1'b1;
            state_d    = ST_SEND;
          end else if (word_q == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
            tx_data_d  = csum_q;
            tx_start_d = 1'b1;
            state_d    = ST_CSUM_SEND;
`else
            done_d     = 1'b1;
            state_d    = ST_FIN;
`endif
          end else begin
            word_d  = word_q + 1'b1;
            state_d = ST_REQ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_SEND: state_d = ST_CSUM_WAIT;
      ST_CSUM_WAIT: begin
        if (bus.i_tx_done) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_debug          = (state_q != ST_IDLE);
  assign bus.o_busy           = (state_q != ST_IDLE);
  assign bus.o_debug_mem_addr = NB_DATA'(word_q);
  assign bus.o_tx_data        = tx_data_q;
  assign bus.o_tx_start       = tx_start_q;
  assign bus.o_done           = done_q;

endmodule

// File: tb/tb_debug_mem_dump.sv
// Directed self-checking bench for debug_mem_dump: synchronous memory model, latency-configurable TX responder,
// and a byte scoreboard built from the memory contents before each dump.
module tb_debug_mem_dump;

  logic clk;
  logic reset;

  debug_mem_dump_if #(.NB_DATA(32), .NB_BYTE(8)) bus ();

  debug_mem_dump dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mem [32];
  int          txLatency = 5;
  logic        injectDone = 1'b0;

  logic [7:0]  capBytes[$];
  int          capAddr[$];
  int          capCycle[$];
  logic [7:0]  expBytes[$];
  int          cycle = 0;
  int          doneCount = 0;
  int          doneCycle = 0;
  int          lastTxDoneCycle = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Synchronous read: data for the address held in REQ is valid during LATCH.
  initial begin
    bus.i_debug_mem_r_data = '0;
    forever begin
      @(posedge clk);
      #1 bus.i_debug_mem_r_data = mem[bus.o_debug_mem_addr[4:0]];
    end
  end

  initial begin
    int pending = 0;
    bus.i_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_done = injectDone;
      if (pending > 0) begin
        pending--;
        if (pending == 0) bus.i_tx_done = 1'b1;
      end
      if (bus.o_tx_start) pending = txLatency;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (bus.o_tx_start) begin
        capBytes.push_back(bus.o_tx_data);
        capAddr.push_back(int'(bus.o_debug_mem_addr));
        capCycle.push_back(cycle);
      end
      if (bus.i_tx_done) lastTxDoneCycle = cycle;
      if (bus.o_done) begin
        doneCount++;
        doneCycle = cycle;
      end
    end
  end

  task automatic buildExpected();
    logic [31:0] w;
    logic [7:0]  x;
    expBytes.delete();
    x = '0;
    for (int i = 0; i < 32; i++) begin
      w = mem[i];
      for (int b = 0; b < 4; b++) begin
        expBytes.push_back(w[31-8*b -: 8]);
        x = x ^ w[31-8*b -: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    expBytes.push_back(x);
`endif
  endtask

  task automatic applyStimulus(input int latency);
    txLatency = latency;
    capBytes.delete();
    capAddr.delete();
    capCycle.delete();
    doneCount = 0;
    buildExpected();
    @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic finishDump(input string tag);
    int budget = 8000;
    int n;
    while (doneCount == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput({tag, "-done-seen"}, 32'(doneCount != 0), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "-done-count"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "-done-timing"}, 32'(doneCycle), 32'(lastTxDoneCycle + 1));
    checkOutput({tag, "-busy-after"}, 32'(bus.o_busy), 32'd0);
    checkOutput({tag, "-byte-count"}, 32'(capBytes.size()), 32'(expBytes.size()));
    n = (capBytes.size() < expBytes.size()) ? capBytes.size() : expBytes.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s-byte%0d", tag, i), 32'(capBytes[i]), 32'(expBytes[i]));
      if (i < 128)
        checkOutput($sformatf("%s-addr%0d", tag, i), 32'(capAddr[i]), 32'(i / 4));
      if (i > 0 && i < 128 && (i % 4) != 0)
        checkOutput($sformatf("%s-gap%0d", tag, i), 32'(capCycle[i] - capCycle[i-1]), 32'(txLatency + 1));
    end
  endtask

  task automatic waitFor(input string tag, input int target, input bit onAddr);
    int budget = 8000;
    while (budget > 0 && (onAddr ? (int'(bus.o_debug_mem_addr) != target || !bus.o_busy)
                                 : (capBytes.size() != target))) begin
      @(posedge clk);
      budget--;
    end
    checkOutput({tag, "-reached"}, 32'(budget > 0), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.i_start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA0B0C000 + 32'(i);

    // Reset held three cycles, with stray tx_done activity that must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 injectDone = ~injectDone;
      @(negedge clk);
      checkOutput("rst-debug", 32'(bus.o_debug), 32'd0);
      checkOutput("rst-addr", bus.o_debug_mem_addr, 32'd0);
      checkOutput("rst-txdata", 32'(bus.o_tx_data), 32'd0);
      checkOutput("rst-txstart", 32'(bus.o_tx_start), 32'd0);
      checkOutput("rst-busy", 32'(bus.o_busy), 32'd0);
      checkOutput("rst-done", 32'(bus.o_done), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 injectDone = ~injectDone;
      @(negedge clk);
      checkOutput("idle-busy", 32'(bus.o_busy), 32'd0);
      checkOutput("idle-txstart", 32'(bus.o_tx_start), 32'd0);
    end
    @(posedge clk);
    #1 injectDone = 1'b0;
    repeat (8) @(posedge clk);

    $display("[TB] full dump, tx latency 5");
    applyStimulus(5);
    finishDump("lat5");

    $display("[TB] back-to-back handshake");
    applyStimulus(1);
    finishDump("lat1");

    $display("[TB] second start during word 10");
    applyStimulus(3);
    waitFor("w10", 10, 1'b1);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    finishDump("restart-ignored");

    $display("[TB] reset while waiting on byte 2 of word 7");
    applyStimulus(5);
    waitFor("w7b2", 7*4 + 3, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst-debug", 32'(bus.o_debug), 32'd0);
    checkOutput("midrst-txstart", 32'(bus.o_tx_start), 32'd0);
    checkOutput("midrst-busy", 32'(bus.o_busy), 32'd0);
    checkOutput("midrst-addr", bus.o_debug_mem_addr, 32'd0);
    repeat (10) @(posedge clk);
    applyStimulus(5);
    finishDump("after-rst");

`ifdef DUMP_CHECKSUM_EN
    $display("[TB] checksum, all words 0x01020304");
    for (int i = 0; i < 32; i++) mem[i] = 32'h01020304;
    applyStimulus(1);
    finishDump("csum-a");
    $display("[TB] checksum, word0 0x000000FF");
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h000000FF;
    applyStimulus(1);
    finishDump("csum-b");
    checkOutput("csum-b-last", 32'(capBytes[capBytes.size()-1]), 32'h000000FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
